// File: rtl/pattern_fsm_pkg.sv
// Shared helpers for serial pattern detectors: width calculation and the
// prefix-function (KMP) next-state rule, usable by any detector length.
package pattern_fsm_pkg;

   localparam int MAX_PAT_W = 16;

   // Smallest r with 2**r >= n.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // The history is the first `state` pattern bits followed by `b`.
   // Returns the longest k (k <= pat_w) such that the first k pattern bits
   // equal the last k history bits. Pattern bit 0 (first received) lives at
   // pattern[pat_w-1]. `state` must be in 0..pat_w.
   function automatic int prefix_next(input logic [MAX_PAT_W-1:0] pattern,
                                      input int pat_w,
                                      input int state,
                                      input logic b);
      int   best;
      int   hidx;
      logic ok;
      logic hb;
      best = 0;
      for (int k = 1; k <= MAX_PAT_W; k++) begin
         if (k <= pat_w && k <= state + 1) begin
            ok = 1'b1;
            for (int i = 0; i < MAX_PAT_W; i++) begin
               if (i < k) begin
                  hidx = state + 1 - k + i;
                  hb   = (hidx < state) ? pattern[4'(pat_w - 1 - hidx)] : b;
                  if (pattern[4'(pat_w - 1 - i)] != hb) ok = 1'b0;
               end
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/pattern_fsm_next.sv
// Combinational next-state logic of the pattern detector: S is the length of
// the pattern prefix matched so far; S==PAT_W means a full match.
module pattern_next
   import pattern_fsm_pkg::*;
#(
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int             OVERLAP = 1,
   parameter int             SW      = clog2(PAT_W + 1)
) (
   input  logic [SW-1:0] s_i,
   input  logic          w_i,
   output logic [SW-1:0] s_next_o
);

   localparam logic [MAX_PAT_W-1:0] PAT_VEC = MAX_PAT_W'(PATTERN);
   localparam logic [SW-1:0]        S_IDLE  = '0;
   localparam logic [SW-1:0]        S_ONE   = SW'(1);
   localparam logic [SW-1:0]        S_FULL  = SW'(PAT_W);

   // Illegal encodings recover to idle; a completed match either keeps its
   // bits as history (overlap) or restarts from the incoming bit alone.
   always_comb begin
      s_next_o = S_IDLE;
      if (s_i > S_FULL) begin
         s_next_o = S_IDLE;
      end else if (s_i == S_FULL && OVERLAP == 0) begin
         s_next_o = (w_i == PATTERN[PAT_W-1]) ? S_ONE : S_IDLE;
      end else begin
         s_next_o = SW'(prefix_next(PAT_VEC, PAT_W, int'(s_i), w_i));
      end
   end

endmodule

// File: rtl/pattern_fsm.sv
// Serial pattern detector: Moore match flag z and a saturating, clearable
// match counter. Next-state logic lives in pattern_next.
module pattern_fsm
   import pattern_fsm_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int               OVERLAP = 1,
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             w,
   input  logic             clr_cnt,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int               SW       = clog2(PAT_W + 1);
   localparam logic [SW-1:0]    S_IDLE   = '0;
   localparam logic [SW-1:0]    S_FULL   = SW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [SW-1:0]    s_q, s_d, s_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   pattern_next #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN),
      .OVERLAP (OVERLAP),
      .SW      (SW)
   ) u_next (
      .s_i      (s_q),
      .w_i      (w),
      .s_next_o (s_nxt)
   );

   // Advance only on enabled samples; count each entry into the full state,
   // letting a clear override a coincident match.
   always_comb begin
      s_d   = s_q;
      cnt_d = cnt_q;
      if (en) s_d = s_nxt;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (en && s_nxt == S_FULL && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q   <= S_IDLE;
         cnt_q <= '0;
      end else begin
         s_q   <= s_d;
         cnt_q <= cnt_d;
      end
   end

   assign z         = (s_q == S_FULL);
   assign match_cnt = cnt_q;

endmodule
